// File: rtl/multi_alarm_ctrl.sv
// Multi-channel alarm controller: per-channel alarm time, edge-detected match, RING/SNOOZE timing.
// Optional snooze support is built when ALARM_SNOOZE_EN is defined.
module multi_alarm_ctrl #(
    parameter int unsigned DATA_WIDTH     = 24,
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned ADDR_WIDTH     = 2,
    parameter int unsigned CLK_PER_SEC    = 52428800,
    parameter int unsigned RING_SECONDS   = 60,
    parameter int unsigned SNOOZE_SECONDS = 300
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] timer_data,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [CHANNELS-1:0]   ch_enable,
    input  logic                  stop,
    input  logic                  snooze,
    output logic                  alarm_out,
    output logic [CHANNELS-1:0]   ringing,
    output logic [ADDR_WIDTH-1:0] active_ch
);

    localparam int unsigned PRE_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
`ifdef ALARM_SNOOZE_EN
    localparam int unsigned CNT_MAX = (RING_SECONDS > SNOOZE_SECONDS) ? RING_SECONDS : SNOOZE_SECONDS;
`else
    localparam int unsigned CNT_MAX = RING_SECONDS;
`endif
    localparam int unsigned CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

`ifdef ALARM_SNOOZE_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RING = 2'd1
    } state_t;

    logic unused_snooze;
    assign unused_snooze = snooze ^ (SNOOZE_SECONDS != 0);
`endif

    logic [DATA_WIDTH-1:0] alarm_time  [CHANNELS];
    logic [CHANNELS-1:0]   eq;
    logic [CHANNELS-1:0]   eq_d;
    logic [CHANNELS-1:0]   match;
    state_t                state       [CHANNELS];
    state_t                state_nxt   [CHANNELS];
    logic [CNT_W-1:0]      sec_cnt     [CHANNELS];
    logic [CNT_W-1:0]      sec_cnt_nxt [CHANNELS];
    logic [PRE_W-1:0]      pre_cnt;
    logic                  sec_tick;

    // Alarm time registers; addresses beyond the last channel decode to nothing.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) alarm_time[i] <= '1;
        end else if (wr_en) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_addr == ADDR_WIDTH'(i)) alarm_time[i] <= wr_data;
            end
        end
    end

    // Compare uses the registered alarm time, so a same-cycle write is seen one cycle later.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) eq[i] = (timer_data == alarm_time[i]);
        match = eq & ~eq_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) eq_d <= '1;
        else        eq_d <= eq;
    end

    // Shared one-second prescaler.
    assign sec_tick = (pre_cnt == PRE_W'(CLK_PER_SEC - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)        pre_cnt <= '0;
        else if (sec_tick) pre_cnt <= '0;
        else               pre_cnt <= pre_cnt + PRE_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state[i]   <= ST_IDLE;
                sec_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state[i]   <= state_nxt[i];
                sec_cnt[i] <= sec_cnt_nxt[i];
            end
        end
    end

    // Per-channel next state; disable beats stop, stop beats snooze.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_nxt[i]   = state[i];
            sec_cnt_nxt[i] = sec_cnt[i];
            if (!ch_enable[i]) begin
                state_nxt[i]   = ST_IDLE;
                sec_cnt_nxt[i] = '0;
            end else if (stop && (state[i] != ST_IDLE)) begin
                state_nxt[i]   = ST_IDLE;
                sec_cnt_nxt[i] = '0;
            end else begin
                case (state[i])
                    ST_IDLE: begin
                        sec_cnt_nxt[i] = '0;
                        if (match[i]) state_nxt[i] = ST_RING;
                    end
                    ST_RING: begin
`ifdef ALARM_SNOOZE_EN
                        if (snooze) begin
                            state_nxt[i]   = ST_SNOOZE;
                            sec_cnt_nxt[i] = '0;
                        end else
`endif
                        if (sec_tick) begin
                            if (sec_cnt[i] == CNT_W'(RING_SECONDS - 1)) begin
                                state_nxt[i]   = ST_IDLE;
                                sec_cnt_nxt[i] = '0;
                            end else begin
                                sec_cnt_nxt[i] = sec_cnt[i] + CNT_W'(1);
                            end
                        end
                    end
`ifdef ALARM_SNOOZE_EN
                    ST_SNOOZE: begin
                        if (sec_tick) begin
                            if (sec_cnt[i] == CNT_W'(SNOOZE_SECONDS - 1)) begin
                                state_nxt[i]   = ST_RING;
                                sec_cnt_nxt[i] = '0;
                            end else begin
                                sec_cnt_nxt[i] = sec_cnt[i] + CNT_W'(1);
                            end
                        end
                    end
`endif
                    default: begin
                        state_nxt[i]   = ST_IDLE;
                        sec_cnt_nxt[i] = '0;
                    end
                endcase
            end
        end
    end

    // Output decode of registered state; lowest ringing channel wins.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) ringing[i] = (state[i] == ST_RING);
        alarm_out = |ringing;
        active_ch = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (ringing[i]) active_ch = ADDR_WIDTH'(i);
        end
    end

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Directed self-checking bench for multi_alarm_ctrl (4-channel instance plus a 3-channel instance).
module tb_multi_alarm_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [23:0] timer_data;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [23:0] wr_data;
    logic [3:0]  ch_enable;
    logic [2:0]  ch_enable3;
    logic        stop;
    logic        snooze;
    logic        alarm_out;
    logic [3:0]  ringing;
    logic [1:0]  active_ch;
    logic        alarm_out3;
    logic [2:0]  ringing3;
    logic [1:0]  active_ch3;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;

    always #5 clock = ~clock;

    multi_alarm_ctrl #(
        .DATA_WIDTH(24), .CHANNELS(4), .ADDR_WIDTH(2),
        .CLK_PER_SEC(4), .RING_SECONDS(3), .SNOOZE_SECONDS(2)
    ) u_dut (
        .clock(clock), .reset(reset), .timer_data(timer_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ch_enable(ch_enable), .stop(stop), .snooze(snooze),
        .alarm_out(alarm_out), .ringing(ringing), .active_ch(active_ch)
    );

    multi_alarm_ctrl #(
        .DATA_WIDTH(24), .CHANNELS(3), .ADDR_WIDTH(2),
        .CLK_PER_SEC(4), .RING_SECONDS(3), .SNOOZE_SECONDS(2)
    ) u_dut3 (
        .clock(clock), .reset(reset), .timer_data(timer_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ch_enable(ch_enable3), .stop(stop), .snooze(snooze),
        .alarm_out(alarm_out3), .ringing(ringing3), .active_ch(active_ch3)
    );

    // Edges since reset release; the prescaler value equals cyc mod 4.
    always @(posedge clock or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_alarm(input logic [1:0] addr, input logic [23:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        int n_e;
        int len;
        reset      = 1'b0;
        timer_data = 24'hFFFFFF;
        wr_en      = 1'b0;
        wr_addr    = 2'd0;
        wr_data    = 24'd0;
        ch_enable  = 4'hF;
        ch_enable3 = 3'h7;
        stop       = 1'b0;
        snooze     = 1'b0;
        #12;
        check("reset_ringing", 32'(ringing), 32'h0);
        check("reset_alarm_out", 32'(alarm_out), 32'h0);
        check("reset_active_ch", 32'(active_ch), 32'h0);
        check("reset_ringing3", 32'(ringing3), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        tick(); tick(); tick();
        check("no_ring_on_all_ones", 32'(ringing), 32'h0);

        // Single channel ring and its timed release.
        timer_data = 24'h000000;
        write_alarm(2'd1, 24'h123000);
        timer_data = 24'h123000;
        check("req037_before_edge", 32'(ringing), 32'h0);
        tick();
        check("req037_ringing", 32'(ringing), 32'h2);
        check("req037_active_ch", 32'(active_ch), 32'h1);
        check("req037_alarm_out", 32'(alarm_out), 32'h1);
        n_e = cyc;
        len = 1;
        while (ringing[1] && len < 20) begin
            tick();
            if (ringing[1]) len++;
        end
        check("req037_ring_len", 32'(len), 32'(((7 - (n_e % 4)) % 4) + 9));
        timer_data = 24'h000000;
        tick();

        // Same-cycle write compares against the old alarm time.
        timer_data = 24'h050000;
        write_alarm(2'd0, 24'h050000);
        check("req021_prewrite", 32'(ringing), 32'h0);
        tick();
        check("req021_next", 32'(ringing), 32'h1);
        pulse_stop();
        check("req021_stopped", 32'(ringing), 32'h0);

        // Two channels on one time; stop beats snooze.
        timer_data = 24'h000000;
        write_alarm(2'd0, 24'h070000);
        write_alarm(2'd2, 24'h070000);
        timer_data = 24'h070000;
        tick();
        check("req038_ringing", 32'(ringing), 32'h5);
        check("req038_active_ch", 32'(active_ch), 32'h0);
        check("req038_alarm_out", 32'(alarm_out), 32'h1);
        stop   = 1'b1;
        snooze = 1'b1;
        tick();
        stop   = 1'b0;
        snooze = 1'b0;
        check("req040_stop_prio", 32'(ringing), 32'h0);
        for (int i = 0; i < 6; i++) tick();
        check("req040_no_rering", 32'(ringing), 32'h0);

        // Snooze on channel 3.
        timer_data = 24'h000000;
        write_alarm(2'd3, 24'h0A0000);
        timer_data = 24'h0A0000;
        tick();
        check("req039_ringing", 32'(ringing), 32'h8);
        check("req039_active_ch", 32'(active_ch), 32'h3);
        snooze = 1'b1;
        tick();
        snooze = 1'b0;
`ifdef ALARM_SNOOZE_EN
        check("req039_snoozed", 32'(ringing), 32'h0);
        n_e = cyc;
        len = 1;
        while (!ringing[3] && len < 20) begin
            tick();
            if (!ringing[3]) len++;
        end
        check("req039_snooze_len", 32'(len), 32'(((7 - (n_e % 4)) % 4) + 5));
        check("req039_back", 32'(ringing), 32'h8);
`else
        check("req039_ignored", 32'(ringing), 32'h8);
`endif
        pulse_stop();
        check("req039_stopped", 32'(ringing), 32'h0);

        // Channel disable and asynchronous reset mid-ring.
        timer_data = 24'h000000;
        write_alarm(2'd2, 24'h0B0000);
        timer_data = 24'h0B0000;
        tick();
        check("req041_ringing", 32'(ringing), 32'h4);
        ch_enable = 4'b1011;
        tick();
        check("req041_disable", 32'(ringing), 32'h0);
        ch_enable = 4'hF;
        tick(); tick();
        check("req041_no_rering", 32'(ringing), 32'h0);
        timer_data = 24'h000000;
        tick();
        timer_data = 24'h0B0000;
        tick();
        check("req041_rering", 32'(ringing), 32'h4);
        #3;
        reset = 1'b0;
        #1;
        check("req041_async_ringing", 32'(ringing), 32'h0);
        check("req041_async_alarm_out", 32'(alarm_out), 32'h0);
        check("req041_async_active_ch", 32'(active_ch), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        tick();

        // Out-of-range address on the 3-channel instance.
        timer_data = 24'h000000;
        write_alarm(2'd3, 24'h0C0000);
        timer_data = 24'h0C0000;
        tick();
        check("req042_ignored", 32'(ringing3), 32'h0);
        check("req042_alarm_out", 32'(alarm_out3), 32'h0);
        check("req042_ref4ch", 32'(ringing), 32'h8);
        timer_data = 24'h000000;
        write_alarm(2'd2, 24'h0D0000);
        timer_data = 24'h0D0000;
        tick();
        check("req042_valid", 32'(ringing3), 32'h4);
        check("req042_active_ch", 32'(active_ch3), 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
